// File: rtl/hand_dealer.sv
// ---------------------------------------------------------------------------
// hand_dealer
//
// Game-sequencing stage that sits directly after card_deal. It asks for a
// reshuffle, then pulls cards one at a time and places them as Texas hold'em
// hole cards for NUM_PLAYERS seats and as the five board cards. Game control
// moves the hand forward one phase at a time with `advance`.
//
// Build option: define BURN_CARD_EN to burn one card before the flop, the
// turn and the river. Hole-card dealing is the same in both builds.
//
// Parameters:
//   NUM_PLAYERS     seats dealt hole cards (2..8)
//   TIMEOUT_CYCLES  cycles a request may wait for card_valid (1..255)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   start_hand   pulse: abort whatever is going on, reshuffle, start a new hand
//   advance      pulse: deal the next phase (honoured only in READY)
//   shuffled     card_deal: deck shuffle complete
//   card         card_deal: {suit[1:0], rank[3:0]}
//   card_valid   card_deal: card is valid
//   new_hand     to card_deal: reshuffle request (one cycle)
//   next_card    to card_deal: card request
//   hole_cards   seat p at [12p+11:12p]; hole card 0 low, hole card 1 high
//   board        board card i at [6i+5:6i]; 0..2 flop, 3 turn, 4 river
//   board_valid  bit i set once board card i is loaded
//   phase        0 idle, 1 hole dealt, 2 flop, 3 turn, 4 river/showdown
//   dealing      high while a phase is being dealt
//   deal_done    one-cycle pulse when a phase completes
//   timeout_err  sticky: card_valid never arrived for a request
//   state_dbg    current FSM state encoding
//
// Card handshake with card_deal (valid/ready rules):
//   next_card rises in REQ and stays high until card_valid is sampled high;
//   on that edge the card is captured and next_card drops. The block then
//   waits in RELEASE for card_valid to fall, spends one GAP cycle with
//   next_card low so card_deal can prefetch, and only then may request again.
// ---------------------------------------------------------------------------
module hand_dealer #(
    parameter int NUM_PLAYERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_hand,
    input  logic                      advance,
    input  logic                      shuffled,
    input  logic [5:0]                card,
    input  logic                      card_valid,
    output logic                      new_hand,
    output logic                      next_card,
    output logic [12*NUM_PLAYERS-1:0] hole_cards,
    output logic [29:0]               board,
    output logic [4:0]                board_valid,
    output logic [2:0]                phase,
    output logic                      dealing,
    output logic                      deal_done,
    output logic                      timeout_err,
    output logic [2:0]                state_dbg
);

`ifdef BURN_CARD_EN
    localparam bit       BURN_EN  = 1'b1;
    localparam bit [2:0] BURN_NUM = 3'd1;
`else
    localparam bit       BURN_EN  = 1'b0;
    localparam bit [2:0] BURN_NUM = 3'd0;
`endif

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] HOLE_QUOTA = 5'(2 * NUM_PLAYERS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHUF_REQ  = 3'd1,
        S_WAIT_SHUF = 3'd2,
        S_READY     = 3'd3,
        S_REQ       = 3'd4,
        S_RELEASE   = 3'd5,
        S_GAP       = 3'd6
    } state_t;

    state_t                    state, state_d;
    logic [4:0]                quota, quota_d;   // cards still to fetch this phase
    logic [4:0]                slot, slot_d;     // cards already fetched this phase
    logic [7:0]                tmo_cnt, tmo_d;
    logic [12*NUM_PLAYERS-1:0] hole_d;
    logic [29:0]               board_d;
    logic [4:0]                bv_d;
    logic [2:0]                phase_d;
    logic                      dealing_d, deal_done_d, err_d;
    logic                      new_hand_d, next_card_d;
    logic [4:0]                phase_quota;
    logic [2:0]                board_base, board_idx;

    assign state_dbg = state;

    // Number of cards to fetch for the phase about to be dealt.
    always_comb begin
        phase_quota = 5'(3'd1 + BURN_NUM);
        case (phase)
            3'd0:    phase_quota = HOLE_QUOTA;
            3'd1:    phase_quota = 5'(3'd3 + BURN_NUM);
            default: phase_quota = 5'(3'd1 + BURN_NUM);
        endcase
    end

    // Board slot targeted by the current card. With burning enabled slot 0
    // of each board phase is the burn card, so the board index is shifted.
    always_comb begin
        board_base = 3'd4;
        case (phase)
            3'd1:    board_base = 3'd0;
            3'd2:    board_base = 3'd3;
            default: board_base = 3'd4;
        endcase
        board_idx = board_base + slot[2:0] - BURN_NUM;
    end

    always_comb begin
        state_d     = state;
        quota_d     = quota;
        slot_d      = slot;
        tmo_d       = 8'd0;
        hole_d      = hole_cards;
        board_d     = board;
        bv_d        = board_valid;
        phase_d     = phase;
        dealing_d   = dealing;
        deal_done_d = 1'b0;
        err_d       = timeout_err;

        if (start_hand) begin
            // Abort from any state: everything about the old hand is dropped.
            state_d   = S_SHUF_REQ;
            quota_d   = 5'd0;
            slot_d    = 5'd0;
            hole_d    = '0;
            board_d   = '0;
            bv_d      = '0;
            phase_d   = 3'd0;
            dealing_d = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state)
                S_IDLE: ;
                S_SHUF_REQ: state_d = S_WAIT_SHUF;
                S_WAIT_SHUF: if (shuffled) state_d = S_READY;
                S_READY: begin
                    if (advance && (phase < 3'd4)) begin
                        state_d   = S_REQ;
                        dealing_d = 1'b1;
                        quota_d   = phase_quota;
                        slot_d    = 5'd0;
                    end
                end
                S_REQ: begin
                    if (card_valid) begin
                        if (phase == 3'd0) begin
                            // Round-robin: first pass fills hole card 0 of
                            // every seat, second pass fills hole card 1.
                            for (int p = 0; p < NUM_PLAYERS; p++) begin
                                if (slot == 5'(p))
                                    hole_d[12*p +: 6] = card;
                                if (slot == 5'(NUM_PLAYERS + p))
                                    hole_d[12*p+6 +: 6] = card;
                            end
                        end else if (!(BURN_EN && (slot == 5'd0))) begin
                            for (int i = 0; i < 5; i++) begin
                                if (board_idx == 3'(i)) begin
                                    board_d[6*i +: 6] = card;
                                    bv_d[i]           = 1'b1;
                                end
                            end
                        end
                        slot_d  = slot + 5'd1;
                        quota_d = quota - 5'd1;
                        state_d = S_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Cards captured so far stay; phase is not advanced.
                        err_d     = 1'b1;
                        dealing_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        tmo_d = tmo_cnt + 8'd1;
                    end
                end
                S_RELEASE: if (!card_valid) state_d = S_GAP;
                S_GAP: begin
                    if (quota != 5'd0) begin
                        state_d = S_REQ;
                    end else begin
                        phase_d     = phase + 3'd1;
                        deal_done_d = 1'b1;
                        dealing_d   = 1'b0;
                        state_d     = S_READY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Handshake outputs follow the registered state one-for-one.
        new_hand_d  = (state_d == S_SHUF_REQ);
        next_card_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            quota       <= 5'd0;
            slot        <= 5'd0;
            tmo_cnt     <= 8'd0;
            hole_cards  <= '0;
            board       <= '0;
            board_valid <= '0;
            phase       <= 3'd0;
            dealing     <= 1'b0;
            deal_done   <= 1'b0;
            timeout_err <= 1'b0;
            new_hand    <= 1'b0;
            next_card   <= 1'b0;
        end else begin
            state       <= state_d;
            quota       <= quota_d;
            slot        <= slot_d;
            tmo_cnt     <= tmo_d;
            hole_cards  <= hole_d;
            board       <= board_d;
            board_valid <= bv_d;
            phase       <= phase_d;
            dealing     <= dealing_d;
            deal_done   <= deal_done_d;
            timeout_err <= err_d;
            new_hand    <= new_hand_d;
            next_card   <= next_card_d;
        end
    end

endmodule

// File: tb/tb_hand_dealer.sv
// ---------------------------------------------------------------------------
// tb_hand_dealer
//
// Directed bench for hand_dealer (NUM_PLAYERS=2, TIMEOUT_CYCLES=255). The
// bench plays card_deal: it answers each request with a card chosen by the
// test step. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hand_dealer;

    localparam int NP = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SHUF = 3'd2;
    localparam logic [2:0] ST_READY     = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start_hand = 1'b0;
    logic            advance = 1'b0;
    logic            shuffled = 1'b0;
    logic [5:0]      card = 6'd0;
    logic            card_valid = 1'b0;
    logic            new_hand;
    logic            next_card;
    logic [12*NP-1:0] hole_cards;
    logic [29:0]     board;
    logic [4:0]      board_valid;
    logic [2:0]      phase;
    logic            dealing;
    logic            deal_done;
    logic            timeout_err;
    logic [2:0]      state_dbg;

    int checks = 0;
    int errors = 0;
    int reqs   = 0;

    hand_dealer #(.NUM_PLAYERS(NP), .TIMEOUT_CYCLES(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_hand  (start_hand),
        .advance     (advance),
        .shuffled    (shuffled),
        .card        (card),
        .card_valid  (card_valid),
        .new_hand    (new_hand),
        .next_card   (next_card),
        .hole_cards  (hole_cards),
        .board       (board),
        .board_valid (board_valid),
        .phase       (phase),
        .dealing     (dealing),
        .deal_done   (deal_done),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_hand = 1'b1;
        shuffled   = 1'b0;
        tick();
        start_hand = 1'b0;
    endtask

    // Called right after pulse_start: new_hand must be a single-cycle pulse.
    task automatic shuffle_to_ready();
        check("new_hand_high", new_hand, 1'b1);
        tick();
        check("new_hand_once", new_hand, 1'b0);
        check("wait_shuf", state_dbg, ST_WAIT_SHUF);
        tick(9);
        shuffled = 1'b1;
        tick();
        check("ready", state_dbg, ST_READY);
    endtask

    task automatic do_advance();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    // Serve one card: wait (bounded) for the request, present the card for
    // one cycle, then confirm the request dropped and stayed low over GAP.
    task automatic serve(input logic [5:0] c);
        int n = 0;
        while (!next_card && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", next_card, 1'b1);
        check("dealing_high", dealing, 1'b1);
        card       = c;
        card_valid = 1'b1;
        reqs++;
        tick();
        check("req_dropped", next_card, 1'b0);
        card_valid = 1'b0;
        tick();
        check("gap_no_req", next_card, 1'b0);
        check("gap_state", state_dbg, ST_GAP);
    endtask

    task automatic phase_end(input logic [2:0] ph);
        tick();
        check("deal_done_pulse", deal_done, 1'b1);
        check("phase", phase, ph);
        check("dealing_low", dealing, 1'b0);
        check("back_ready", state_dbg, ST_READY);
        tick();
        check("deal_done_once", deal_done, 1'b0);
    endtask

    initial begin
        int cyc;

        // Reset state
        tick(2);
        check("rst_new_hand", new_hand, 1'b0);
        check("rst_next_card", next_card, 1'b0);
        check("rst_hole", hole_cards, '0);
        check("rst_board", board, '0);
        check("rst_bv", board_valid, '0);
        check("rst_phase", phase, 3'd0);
        check("rst_flags", {dealing, deal_done, timeout_err}, 3'b000);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b1;
        tick();

        // Start a hand
        pulse_start();
        shuffle_to_ready();
        check("start_phase", phase, 3'd0);
        check("start_dealing", dealing, 1'b0);

        // Hole cards: round-robin over two seats
        do_advance();
        serve(6'h02);
        serve(6'h03);
        serve(6'h04);
        serve(6'h05);
        phase_end(3'd1);
        check("seat0", hole_cards[11:0], {6'h04, 6'h02});
        check("seat1", hole_cards[23:12], {6'h05, 6'h03});

        // Flop, turn, river
        reqs = 0;
`ifdef BURN_CARD_EN
        do_advance();
        serve(6'h20); serve(6'h21); serve(6'h22); serve(6'h23);
        phase_end(3'd2);
        check("flop_bv", board_valid, 5'b00111);
        do_advance();
        serve(6'h24); serve(6'h25);
        phase_end(3'd3);
        do_advance();
        serve(6'h26); serve(6'h27);
        phase_end(3'd4);
        check("board", board, {6'h27, 6'h25, 6'h23, 6'h22, 6'h21});
        check("board_reqs", reqs, 8);
`else
        do_advance();
        serve(6'h12); serve(6'h13); serve(6'h14);
        phase_end(3'd2);
        check("flop_bv", board_valid, 5'b00111);
        do_advance();
        serve(6'h15);
        phase_end(3'd3);
        check("turn_bv", board_valid, 5'b01111);
        do_advance();
        serve(6'h16);
        phase_end(3'd4);
        check("board", board, {6'h16, 6'h15, 6'h14, 6'h13, 6'h12});
        check("board_reqs", reqs, 5);
`endif
        check("river_bv", board_valid, 5'b11111);

        // Advance at phase 4 is ignored
        do_advance();
        for (int i = 0; i < 5; i++) begin
            check("no_req_phase4", next_card, 1'b0);
            tick();
        end
        check("phase4_state", state_dbg, ST_READY);
        check("phase4_phase", phase, 3'd4);
        check("phase4_dealing", dealing, 1'b0);

        // New hand clears, then let the flop request time out
        pulse_start();
        check("clr_phase", phase, 3'd0);
        check("clr_bv", board_valid, 5'b0);
        check("clr_board", board, 30'd0);
        check("clr_hole", hole_cards, '0);
        shuffle_to_ready();
        do_advance();
        serve(6'h2A); serve(6'h2B); serve(6'h2C); serve(6'h2D);
        phase_end(3'd1);
        do_advance();
        cyc = 0;
        while (!timeout_err && cyc < 400) begin
            tick();
            cyc++;
        end
        check("tmo_cycles", cyc, 255);
        check("tmo_err", timeout_err, 1'b1);
        check("tmo_next_card", next_card, 1'b0);
        check("tmo_state", state_dbg, ST_IDLE);
        check("tmo_dealing", dealing, 1'b0);
        check("tmo_phase", phase, 3'd1);
        check("tmo_hole_kept", hole_cards, {6'h2D, 6'h2B, 6'h2C, 6'h2A});
        tick(3);
        check("tmo_sticky", timeout_err, 1'b1);

        pulse_start();
        check("tmo_cleared", timeout_err, 1'b0);
        shuffle_to_ready();

        // Abort in the middle of the flop
        do_advance();
        serve(6'h01); serve(6'h02); serve(6'h03); serve(6'h04);
        phase_end(3'd1);
        do_advance();
        serve(6'h31);
        serve(6'h32);
        cyc = 0;
        while (!next_card && cyc < 20) begin
            tick();
            cyc++;
        end
        check("abort_req_pending", next_card, 1'b1);
`ifdef BURN_CARD_EN
        check("abort_pre_bv", board_valid, 5'b00001);
`else
        check("abort_pre_bv", board_valid, 5'b00011);
`endif
        start_hand = 1'b1;
        shuffled   = 1'b0;
        tick();
        start_hand = 1'b0;
        check("abort_next_card", next_card, 1'b0);
        check("abort_bv", board_valid, 5'b0);
        check("abort_phase", phase, 3'd0);
        check("abort_board", board, 30'd0);
        check("abort_hole", hole_cards, '0);
        check("abort_new_hand", new_hand, 1'b1);
        check("abort_dealing", dealing, 1'b0);
        card       = 6'h3F;
        card_valid = 1'b1;
        tick();
        card_valid = 1'b0;
        check("stale_board", board, 30'd0);
        check("stale_bv", board_valid, 5'b0);
        check("stale_state", state_dbg, ST_WAIT_SHUF);
        check("stale_next_card", next_card, 1'b0);
        tick();
        check("stale_board_later", board, 30'd0);
        check("abort_new_hand_once", new_hand, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
